// File: rtl/fft_pair_feeder_if.sv
// Stream, twiddle-ROM and butterfly-operand signals of fft_pair_feeder.
interface fft_pair_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
);
  localparam int TWA = $clog2(N) - 1;

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [TWA-1:0]        tw_addr;
  logic [DATA_WIDTH-1:0] tw_data;
  logic [DATA_WIDTH-1:0] x_N;
  logic [DATA_WIDTH-1:0] x_M;
  logic [DATA_WIDTH-1:0] w_N;
  logic                  pair_valid;
  logic                  pair_last;
  logic                  y_valid;

  modport master (
    output s_valid, s_data, tw_data,
    input  s_ready, tw_addr, x_N, x_M, w_N, pair_valid, pair_last, y_valid
  );

  modport slave (
    input  s_valid, s_data, tw_data,
    output s_ready, tw_addr, x_N, x_M, w_N, pair_valid, pair_last, y_valid
  );
endinterface

// File: rtl/fft_pair_feeder.sv
// Buffers one N-sample frame, then issues N/2 radix-2 operand pairs with twiddles.
// FFT_FEED_BITREV_EN: store incoming samples at bit-reversed addresses.
module fft_pair_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16,
  parameter int STAGE      = 0
) (
  input logic              clk,
  input logic              rst,
  fft_pair_feeder_if.slave bus
);
  localparam int AW   = $clog2(N);
  localparam int TW   = AW - 1;
  localparam int HALF = N >> (STAGE + 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         wr_cnt;
  logic [TW-1:0]         k;
  logic [DATA_WIDTH-1:0] mem [N];
  logic                  accept, issue, ready;
  logic [AW-1:0]         waddr, kk, j_a, g_a, idx_n, idx_m;
  logic [TW-1:0]         tw_comb, tw_hold;
  logic [DATA_WIDTH-1:0] rd_n, rd_m;
  logic                  rd_v, rd_last;
  logic [DATA_WIDTH-1:0] xn_q, xm_q, w_q;
  logic                  pv_q, pl_q, yv1, yv2;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

`ifdef FFT_FEED_BITREV_EN
  assign waddr = bitrev(wr_cnt);
`else
  assign waddr = wr_cnt;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (state)
      FILL: begin
        ready  = ~rst;
        accept = bus.s_valid & ~rst;
        if (accept && wr_cnt == AW'(N - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        issue = 1'b1;
        if (k == TW'(N / 2 - 1)) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Pair k: j = k mod HALF and g = k / HALF, both as bit fields since HALF is a power of 2.
  always_comb begin
    kk      = AW'(k);
    j_a     = kk & AW'(HALF - 1);
    g_a     = kk >> (AW - STAGE - 1);
    idx_n   = (g_a << (AW - STAGE)) | j_a;
    idx_m   = idx_n + AW'(HALF);
    tw_comb = TW'(j_a << STAGE);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[waddr] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      wr_cnt  <= '0;
      k       <= '0;
      tw_hold <= '0;
      rd_n    <= '0;
      rd_m    <= '0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      xn_q    <= '0;
      xm_q    <= '0;
      w_q     <= '0;
      pv_q    <= 1'b0;
      pl_q    <= 1'b0;
      yv1     <= 1'b0;
      yv2     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) wr_cnt <= wr_cnt + 1'b1;
      if (issue) begin
        k       <= k + 1'b1;
        tw_hold <= tw_comb;
        rd_n    <= mem[idx_n];
        rd_m    <= mem[idx_m];
      end
      rd_v    <= issue;
      rd_last <= issue && (k == TW'(N / 2 - 1));
      // Operands wait one cycle here so they line up with the ROM's read latency.
      if (rd_v) begin
        xn_q <= rd_n;
        xm_q <= rd_m;
        w_q  <= bus.tw_data;
      end
      pv_q <= rd_v;
      pl_q <= rd_last;
      yv1  <= pv_q;
      yv2  <= yv1;
    end
  end

  assign bus.s_ready    = ready;
  assign bus.tw_addr    = issue ? tw_comb : tw_hold;
  assign bus.x_N        = xn_q;
  assign bus.x_M        = xm_q;
  assign bus.w_N        = w_q;
  assign bus.pair_valid = pv_q;
  assign bus.pair_last  = pl_q;
  assign bus.y_valid    = yv2;
endmodule
